// File: rtl/mem_bus_pkg.sv
// Shared types and defaults for the node memory-bus initiator.
// Bus widths, FSM state encoding and command opcodes.
package mem_bus_pkg;

  localparam int MB_AW = 8;
  localparam int MB_DW = 8;
  localparam int MB_LW = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_READ  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    WRITE = ST_WRITE,
    READ  = ST_READ,
    DRAIN = ST_DRAIN
  } state_e;

  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

endpackage

// File: rtl/mem_bus_master_counter.sv
// Burst address incrementer (wraps mod 2**AW) and beat down-counter.
// last is high once the loaded count has been stepped down to zero.
module mem_burst_counter
  import mem_bus_pkg::*;
#(
  parameter int AW = MB_AW,
  parameter int LW = MB_LW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          step,
  input  logic [AW-1:0] load_addr,
  input  logic [LW:0]   load_cnt,
  output logic [AW-1:0] addr,
  output logic          last
);

  logic [LW:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr <= '0;
      cnt  <= '0;
    end else if (load) begin
      addr <= load_addr;
      cnt  <= load_cnt;
    end else if (step) begin
      addr <= addr + AW'(1);
      cnt  <= cnt - (LW+1)'(1);
    end
  end

  assign last = (cnt == '0);

endmodule

// File: rtl/mem_bus_master.sv
// Initiator for the shared 8-bit tri-state memory bus.
// Sequences single/burst writes and reads; read data returns 3 cycles after accept.
module mem_bus_master
  import mem_bus_pkg::*;
#(
  parameter int AW = MB_AW,
  parameter int DW = MB_DW,
  parameter int LW = MB_LW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_addr,
  input  logic [LW-1:0] cmd_len,
  input  logic [DW-1:0] wr_data,
  input  logic          wr_valid,
  output logic          wr_ready,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic          busy,
  output logic [AW-1:0] mem_addr,
  inout  wire  [DW-1:0] mem_data,
  output logic          mem_write,
  output logic          mem_read
);

  state_e        state;
  logic [DW-1:0] wdata_q;
  logic          iss_q;
  logic          cap_q;
  logic          cmd_fire;
  logic          wr_fire;
  logic          ctr_step;
  logic          ctr_last;
  logic [AW-1:0] cur;
  logic [LW:0]   load_cnt;

  assign cmd_ready = (state == IDLE);
  assign wr_ready  = (state == WRITE);
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign wr_fire   = wr_valid && wr_ready;

  // Reads preload one extra count: the final READ edge holds the bus instead of issuing.
  assign load_cnt = (cmd_write == OP_WR) ?
                    {1'b0, cmd_len} :
                    {1'b0, cmd_len} + (LW+1)'(1);

  assign ctr_step = wr_fire || ((state == READ) && !ctr_last);

  mem_burst_counter #(
    .AW(AW),
    .LW(LW)
  ) u_ctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cmd_fire),
    .step     (ctr_step),
    .load_addr(cmd_addr),
    .load_cnt (load_cnt),
    .addr     (cur),
    .last     (ctr_last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      mem_write <= 1'b0;
      mem_read  <= 1'b0;
      mem_addr  <= '0;
      wdata_q   <= '0;
      iss_q     <= 1'b0;
      cap_q     <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
    end else begin
      mem_write <= 1'b0;
      iss_q     <= 1'b0;
      cap_q     <= iss_q;
      rd_valid  <= cap_q;
      if (cap_q) rd_data <= mem_data;
      unique case (state)
        IDLE: begin
          mem_read <= 1'b0;
          if (cmd_fire)
            state <= (cmd_write == OP_WR) ? WRITE : READ;
        end
        WRITE: begin
          if (wr_fire) begin
            mem_write <= 1'b1;
            mem_addr  <= cur;
            wdata_q   <= wr_data;
            if (ctr_last) state <= IDLE;
          end
        end
        READ: begin
          mem_read <= 1'b1;
          if (ctr_last) begin
            state <= DRAIN;
          end else begin
            mem_addr <= cur;
            iss_q    <= 1'b1;
          end
        end
        DRAIN: begin
          mem_read <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  assign busy = (state != IDLE) || mem_write || mem_read ||
                iss_q || cap_q;

  assign mem_data = mem_write ? wdata_q : {DW{1'bz}};

endmodule
